card_dealer: RTL and testbench
==============================

CARD_DEALER -- requirements
Module: card_dealer

Interface
REQ-001 The block SHALL have clock clk, input, 1 bit: rising-edge clock for all state.
REQ-002 The block SHALL have reset rst_n, input, 1 bit: asynchronous, active-low.
REQ-003 The block SHALL have new_hand, input, 1 bit: synchronous clear of both hands and abort of any request.
REQ-004 The block SHALL have deal_start, input, 1 bit: one-cycle pulse that starts the initial 4-card deal.
REQ-005 The block SHALL have hit, input, 1 bit: one-cycle pulse requesting one card for the player.
REQ-006 The block SHALL have dealer_draw, input, 1 bit: level input; while high, the dealer draws until its score is at least 17.
REQ-007 The block SHALL have card_req, output, 1 bit: card request to the deck.
REQ-008 The block SHALL have card_ack, input, 1 bit: deck acknowledge; card_rank is valid in the same cycle.
REQ-009 The block SHALL have card_rank, input, 4 bits: 1=A, 2..10, 11..13=J/Q/K.
REQ-010 The block SHALL have player_score and dealer_score, outputs, 5 bits each: best hand value, saturating at 31.
REQ-011 The block SHALL have player_cards and dealer_cards, outputs, 4 bits each: card count per hand.
REQ-012 The block SHALL have busy, output, 1 bit: high in any state other than IDLE.
REQ-013 The block SHALL have card_err, output, 1 bit: one-cycle pulse when an invalid rank is received.

Function
REQ-014 The FSM SHALL have states IDLE, DEAL_REQ, HIT_REQ and DRAW_REQ.
REQ-015 In IDLE, priority SHALL be deal_start > hit > dealer_draw; a trigger moves the FSM to its REQ state on the next edge.
REQ-016 In any REQ state, card_req SHALL be held high until the cycle card_ack=1.
REQ-017 card_req SHALL be low in the cycle after the ack.
REQ-018 card_ack SHALL be ignored while card_req is low.
REQ-019 DEAL_REQ SHALL issue 4 sequential requests assigned player, dealer, player, dealer via a 2-bit index, then return to IDLE.
REQ-020 HIT_REQ and DRAW_REQ SHALL each issue one request, then return to IDLE.
REQ-021 A DRAW_REQ SHALL be entered only if dealer_score < 17 and dealer_cards < 11.
REQ-022 hit SHALL be honoured only if player_score < 21 and player_cards < 11.
REQ-023 hit, deal_start and dealer_draw SHALL be dropped while busy, with no queueing.
REQ-024 Card value SHALL be: A=1 hard, 2..10 face value, 11..13=10.
REQ-025 The hard sum SHALL be 6 bits, saturating at 63.
REQ-026 The ace count SHALL be 4 bits.
REQ-027 The score SHALL be hard+10 if ace_count>0 and hard+10<=21, else hard, with the output saturated at 31.
REQ-028 Scores and counts SHALL update on the clock edge that samples the ack and be visible the next cycle, giving 1-cycle latency.
REQ-029 Score outputs SHALL be registered, with no combinational path from card_rank.
REQ-030 An ack with rank 0, 14 or 15 SHALL pulse card_err, change no hand, and keep card_req high for a reissue within the same state and index.
REQ-031 new_hand SHALL have priority over everything: it zeroes hands, counts and index, sets the FSM to IDLE and drops card_req on the next edge.
REQ-032 An ack in the same cycle as new_hand SHALL be discarded.
REQ-033 deal_start SHALL not clear the hands implicitly; the controller pulses new_hand first.

Reset
REQ-034 While rst_n=0 the block SHALL be in IDLE.
REQ-035 While rst_n=0, card_req, busy and card_err SHALL be 0.
REQ-036 While rst_n=0, all scores, counts, ace counts and the index SHALL be 0.
REQ-037 A reset mid-request SHALL drop card_req immediately and asynchronously; the deck sees no ack obligation.

Structure
REQ-038 Shared package bj_pkg SHALL hold: SCORE_W=5, RANK_W=4, BLACKJACK=21, DEALER_STAND=17, MAX_CARDS=11, rank constants ACE/JACK/QUEEN/KING, and the FSM state encoding.
REQ-039 Sub-module hand_accum SHALL be instantiated twice, for player and dealer, and hold add_card/rank/clear inputs, the hard sum, the ace count, the card count and the registered best score.

Verification
REQ-040 Initial deal: new_hand, deal_start, ranks A,9,K,7 each acked after 2 cycles -> player_score=21, dealer_score=16, player_cards=2, dealer_cards=2, busy low.
REQ-041 Soft ace to hard: player A,6 (score 17), then hit with rank 10 -> player_score=17; hit with 9 -> player_score=26.
REQ-042 Dealer draw: dealer 10,6 and dealer_draw held; ranks 5 then 2 -> exactly one draw, dealer_score=21, no second card_req.
REQ-043 Invalid rank: ack with rank 15 mid-deal -> card_err pulse, card_req stays high, counts unchanged; next ack of 4 is assigned to the same hand.
REQ-044 Abort: new_hand while card_req is high with a simultaneous ack of 10 -> next cycle card_req=0, IDLE, all scores 0.
REQ-045 Busy drop and reset: hit during DEAL_REQ is ignored (player_cards=2 after deal); rst_n low mid-request -> card_req=0 the same cycle, all outputs 0.

Source files
------------

// File: rtl/bj_pkg.sv
// +----------------------------------------------------------------------------+
// | bj_pkg                                                                     |
// | Shared constants, FSM encoding and card helpers for the card dealer.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package bj_pkg;

    localparam int SCORE_W = 5;
    localparam int RANK_W  = 4;

    localparam logic [SCORE_W-1:0] BLACKJACK    = 5'd21;
    localparam logic [SCORE_W-1:0] DEALER_STAND = 5'd17;
    localparam logic [3:0]         MAX_CARDS    = 4'd11;

    localparam logic [RANK_W-1:0] ACE   = 4'd1;
    localparam logic [RANK_W-1:0] JACK  = 4'd11;
    localparam logic [RANK_W-1:0] QUEEN = 4'd12;
    localparam logic [RANK_W-1:0] KING  = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEAL_REQ = 2'd1,
        ST_HIT_REQ  = 2'd2,
        ST_DRAW_REQ = 2'd3
    } state_t;

    function automatic logic rank_valid(input logic [RANK_W-1:0] r);
        return (r >= ACE) && (r <= KING);
    endfunction

    // Picture cards count ten; aces count one here and are promoted in best_score.
    function automatic logic [3:0] card_value(input logic [RANK_W-1:0] r);
        return (r >= JACK) ? 4'd10 : r;
    endfunction

    function automatic logic [SCORE_W-1:0] best_score(input logic [5:0] hard,
                                                      input logic [3:0] aces);
        logic [6:0] w_soft;
        w_soft = {1'b0, hard} + 7'd10;
        if ((aces != 4'd0) && (w_soft <= 7'd21))
            return w_soft[SCORE_W-1:0];
        else if (hard > 6'd31)
            return 5'd31;
        else
            return hard[SCORE_W-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/hand_accum.sv
// +----------------------------------------------------------------------------+
// | hand_accum                                                                 |
// | One hand: saturating hard sum, ace count, card count and registered score. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module hand_accum
    import bj_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               add_card,
    input  logic [RANK_W-1:0]  rank,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         cards
);

    logic [5:0]         r_hard;
    logic [3:0]         r_aces;
    logic [3:0]         r_cards;
    logic [SCORE_W-1:0] r_score;

    logic [6:0] w_hard_sum;
    logic [5:0] w_hard_next;
    logic [3:0] w_aces_next;
    logic [3:0] w_cards_next;

    always_comb begin
        w_hard_sum   = {1'b0, r_hard} + {3'b000, card_value(rank)};
        w_hard_next  = (w_hard_sum > 7'd63) ? 6'd63 : w_hard_sum[5:0];
        w_aces_next  = ((rank == ACE) && (r_aces != 4'hF)) ? r_aces + 4'd1 : r_aces;
        w_cards_next = (r_cards != 4'hF) ? r_cards + 4'd1 : r_cards;
    end

    // Score is computed from the next-state sum so it lands on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hard  <= '0;
            r_aces  <= '0;
            r_cards <= '0;
            r_score <= '0;
        end else if (clear) begin
            r_hard  <= '0;
            r_aces  <= '0;
            r_cards <= '0;
            r_score <= '0;
        end else if (add_card) begin
            r_hard  <= w_hard_next;
            r_aces  <= w_aces_next;
            r_cards <= w_cards_next;
            r_score <= best_score(w_hard_next, w_aces_next);
        end
    end

    assign score = r_score;
    assign cards = r_cards;

endmodule

`default_nettype wire

// File: rtl/card_dealer.sv
// +----------------------------------------------------------------------------+
// | card_dealer                                                                |
// | Blackjack deal controller: requests cards from a deck, scores both hands.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module card_dealer
    import bj_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               new_hand,
    input  logic               deal_start,
    input  logic               hit,
    input  logic               dealer_draw,
    output logic               card_req,
    input  logic               card_ack,
    input  logic [RANK_W-1:0]  card_rank,
    output logic [SCORE_W-1:0] player_score,
    output logic [SCORE_W-1:0] dealer_score,
    output logic [3:0]         player_cards,
    output logic [3:0]         dealer_cards,
    output logic               busy,
    output logic               card_err
);

    state_t     r_state;
    logic [1:0] r_idx;
    logic       r_card_req;
    logic       r_card_err;

    logic w_ack;
    logic w_valid;
    logic w_take;
    logic w_to_player;
    logic w_hit_ok;
    logic w_draw_ok;

    assign w_ack       = r_card_req && card_ack && !new_hand;
    assign w_valid     = rank_valid(card_rank);
    assign w_take      = w_ack && w_valid;
    // Deal order alternates player, dealer using the low index bit.
    assign w_to_player = (r_state == ST_HIT_REQ) ||
                         ((r_state == ST_DEAL_REQ) && !r_idx[0]);
    assign w_hit_ok    = (player_score < BLACKJACK) && (player_cards < MAX_CARDS);
    assign w_draw_ok   = (dealer_score < DEALER_STAND) && (dealer_cards < MAX_CARDS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_idx      <= 2'd0;
            r_card_req <= 1'b0;
            r_card_err <= 1'b0;
        end else if (new_hand) begin
            r_state    <= ST_IDLE;
            r_idx      <= 2'd0;
            r_card_req <= 1'b0;
            r_card_err <= 1'b0;
        end else begin
            r_card_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (deal_start) begin
                        r_state    <= ST_DEAL_REQ;
                        r_idx      <= 2'd0;
                        r_card_req <= 1'b1;
                    end else if (hit) begin
                        if (w_hit_ok) begin
                            r_state    <= ST_HIT_REQ;
                            r_card_req <= 1'b1;
                        end
                    end else if (dealer_draw && w_draw_ok) begin
                        r_state    <= ST_DRAW_REQ;
                        r_card_req <= 1'b1;
                    end
                end
                default: begin
                    if (r_card_req) begin
                        if (card_ack) begin
                            if (w_valid) begin
                                r_card_req <= 1'b0;
                                if ((r_state == ST_DEAL_REQ) && (r_idx != 2'd3)) begin
                                    r_idx <= r_idx + 2'd1;
                                end else begin
                                    r_state <= ST_IDLE;
                                    r_idx   <= 2'd0;
                                end
                            end else begin
                                // Bad rank: hold the request so the deck reissues.
                                r_card_err <= 1'b1;
                            end
                        end
                    end else begin
                        r_card_req <= 1'b1;
                    end
                end
            endcase
        end
    end

    hand_accum u_player (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (new_hand),
        .add_card (w_take && w_to_player),
        .rank     (card_rank),
        .score    (player_score),
        .cards    (player_cards)
    );

    hand_accum u_dealer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (new_hand),
        .add_card (w_take && !w_to_player),
        .rank     (card_rank),
        .score    (dealer_score),
        .cards    (dealer_cards)
    );

    assign card_req = r_card_req;
    assign card_err = r_card_err;
    assign busy     = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_card_dealer.sv
// +----------------------------------------------------------------------------+
// | tb_card_dealer                                                             |
// | Directed bench with a hand-content model checked on every falling edge.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_card_dealer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       new_hand = 1'b0;
    logic       deal_start = 1'b0;
    logic       hit = 1'b0;
    logic       dealer_draw = 1'b0;
    logic       card_req;
    logic       card_ack = 1'b0;
    logic [3:0] card_rank = 4'd0;
    logic [4:0] player_score;
    logic [4:0] dealer_score;
    logic [3:0] player_cards;
    logic [3:0] dealer_cards;
    logic       busy;
    logic       card_err;

    int errors = 0;
    int checks = 0;

    int p_q[$];
    int d_q[$];

    card_dealer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .new_hand     (new_hand),
        .deal_start   (deal_start),
        .hit          (hit),
        .dealer_draw  (dealer_draw),
        .card_req     (card_req),
        .card_ack     (card_ack),
        .card_rank    (card_rank),
        .player_score (player_score),
        .dealer_score (dealer_score),
        .player_cards (player_cards),
        .dealer_cards (dealer_cards),
        .busy         (busy),
        .card_err     (card_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Blackjack value of a list of ranks, straight from the card rules.
    function automatic int hand_score(input bit dealer);
        int hard = 0;
        int aces = 0;
        int n;
        int r;
        int best;
        n = dealer ? d_q.size() : p_q.size();
        for (int i = 0; i < n; i++) begin
            r = dealer ? d_q[i] : p_q[i];
            hard += (r > 10) ? 10 : r;
            if (r == 1) aces++;
        end
        if (hard > 63) hard = 63;
        best = (aces > 0 && hard + 10 <= 21) ? hard + 10 : hard;
        return (best > 31) ? 31 : best;
    endfunction

    always @(negedge clk) begin
        chk("p_score", int'(player_score), hand_score(1'b0));
        chk("d_score", int'(dealer_score), hand_score(1'b1));
        chk("p_cards", int'(player_cards), p_q.size());
        chk("d_cards", int'(dealer_cards), d_q.size());
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_new_hand();
        new_hand = 1'b1;
        @(posedge clk);
        p_q.delete();
        d_q.delete();
        #1 new_hand = 1'b0;
    endtask

    task automatic pulse_deal();
        deal_start = 1'b1;
        tick();
        deal_start = 1'b0;
    endtask

    task automatic pulse_hit();
        hit = 1'b1;
        tick();
        hit = 1'b0;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!card_req && n < 50) begin
            tick();
            n++;
        end
        if (!card_req) chk("req_timeout", 0, 1);
    endtask

    // target: 0 player, 1 dealer, 2 rejected rank
    task automatic serve(input int rank, input int delay, input int target);
        wait_req();
        for (int i = 0; i < delay; i++) begin
            tick();
            chk("req_hold", int'(card_req), 1);
        end
        card_rank = rank[3:0];
        card_ack  = 1'b1;
        @(posedge clk);
        if (target == 0) p_q.push_back(rank);
        else if (target == 1) d_q.push_back(rank);
        #1;
        card_ack  = 1'b0;
        card_rank = 4'd0;
        if (target == 2) begin
            chk("err_pulse", int'(card_err), 1);
            chk("req_kept", int'(card_req), 1);
        end else begin
            chk("req_low_after_ack", int'(card_req), 0);
            chk("err_quiet", int'(card_err), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        #12;
        chk("rst_req", int'(card_req), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(card_err), 0);
        chk("rst_pscore", int'(player_score), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Initial deal A,9,K,7
        pulse_new_hand();
        pulse_deal();
        chk("deal_busy", int'(busy), 1);
        serve(1, 2, 0);
        serve(9, 2, 1);
        serve(13, 2, 0);
        serve(7, 2, 1);
        tick();
        chk("deal_p21", int'(player_score), 21);
        chk("deal_d16", int'(dealer_score), 16);
        chk("deal_pc2", int'(player_cards), 2);
        chk("deal_dc2", int'(dealer_cards), 2);
        chk("deal_idle", int'(busy), 0);

        // Soft ace hardening; a hit pulsed mid-deal must be dropped
        pulse_new_hand();
        pulse_deal();
        serve(1, 1, 0);
        pulse_hit();
        serve(10, 1, 1);
        serve(6, 1, 0);
        serve(7, 1, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("dropped_hit_req", int'(card_req), 0);
        end
        chk("dropped_hit_pc", int'(player_cards), 2);
        chk("soft17", int'(player_score), 17);
        pulse_hit();
        serve(10, 1, 0);
        chk("hard17", int'(player_score), 17);
        pulse_hit();
        serve(9, 0, 0);
        chk("bust26", int'(player_score), 26);
        pulse_hit();
        chk("bust_no_hit", int'(card_req), 0);

        // Dealer draws exactly once while dealer_draw is held
        pulse_new_hand();
        pulse_deal();
        serve(2, 0, 0);
        serve(10, 0, 1);
        serve(3, 0, 0);
        serve(6, 0, 1);
        dealer_draw = 1'b1;
        serve(5, 1, 1);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("no_second_draw", int'(card_req), 0);
        end
        chk("dealer21", int'(dealer_score), 21);
        dealer_draw = 1'b0;

        // Invalid rank mid-deal
        pulse_new_hand();
        pulse_deal();
        serve(3, 0, 0);
        serve(15, 1, 2);
        chk("err_dc0", int'(dealer_cards), 0);
        tick();
        chk("err_clear", int'(card_err), 0);
        chk("reissue_req", int'(card_req), 1);
        serve(4, 0, 1);
        chk("reissue_dealer", int'(dealer_score), 4);
        serve(5, 0, 0);
        serve(6, 0, 1);
        tick();
        chk("err_deal_p8", int'(player_score), 8);

        // Abort with simultaneous ack
        pulse_new_hand();
        pulse_deal();
        serve(7, 0, 0);
        wait_req();
        card_rank = 4'd10;
        card_ack  = 1'b1;
        new_hand  = 1'b1;
        @(posedge clk);
        p_q.delete();
        d_q.delete();
        #1;
        card_ack  = 1'b0;
        new_hand  = 1'b0;
        chk("abort_req", int'(card_req), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_pscore", int'(player_score), 0);
        chk("abort_dcards", int'(dealer_cards), 0);
        tick();
        chk("abort_stays_idle", int'(card_req), 0);

        // Asynchronous reset mid-request
        pulse_deal();
        serve(8, 0, 0);
        wait_req();
        #2;
        rst_n = 1'b0;
        p_q.delete();
        d_q.delete();
        #1;
        chk("arst_req", int'(card_req), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_pscore", int'(player_score), 0);
        chk("arst_pcards", int'(player_cards), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_req", int'(card_req), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
